phase_sequencer: RTL and testbench

//  Generates the 3-bit instruction phase (0..7) consumed by the CPU controller, one full

---
 rtl/phase_sequencer.sv | 145 ++++++++++++++
 tb/tb_phase_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: drives the 3-bit phase (0..7) into the CPU
// controller and handles run/stop/single-step control and the controller halt
// strobe. It also counts retired instructions. One instruction spans 8 phases,
// and each phase lasts DIV clock cycles.
//
// Handshake note: start/step/stop are single-cycle request pulses that are
// sampled on the clock edge. There is no ready/acknowledge. A request that does
// not apply to the current state is dropped, and the caller can see what
// happened through running/halted.
module phase_sequencer #(
   parameter int DIV          = 1,
   parameter int CNT_W        = 16,
   parameter bit RUN_ON_RESET = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             step,
   input  logic             stop,
   input  logic             halt,
   output logic [2:0]       phase,
   output logic             adv,
   output logic             running,
   output logic             halted,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_STEP   = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   localparam state_t RST_STATE = RUN_ON_RESET ? S_RUN : S_IDLE;

   state_t             state_q, state_d;
   logic [2:0]         phase_q, phase_d;
   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic               stop_pend_q, stop_pend_d;
   logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;
   logic               running_q, running_d;
   logic               halted_q, halted_d;
   logic               active;
   logic               halt_hit;
   logic               retire;

   // The divider and phase counter move only while an instruction is executing.
   assign active   = (state_q == S_RUN) || (state_q == S_STEP);
   assign adv      = active && (div_cnt_q == DIV_W'(DIV - 1)) && !rst;
   // Halt is checked at the end of phase 4, so it always wins over a retire
   // that would complete later in the same instruction.
   assign halt_hit = adv && (phase_q == 3'd4) && halt;
   assign retire   = adv && (phase_q == 3'd7);

   // Next-state logic: divider, phase, FSM transitions, and the retire counter.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      div_cnt_d   = div_cnt_q;
      stop_pend_d = stop_pend_q;
      instr_cnt_d = instr_cnt_q;

      if (!active) begin
         div_cnt_d = '0;
         phase_d   = 3'd0;
      end else if (adv) begin
         div_cnt_d = '0;
         phase_d   = phase_q + 3'd1;
      end else begin
         div_cnt_d = div_cnt_q + 1'b1;
      end

      if (retire) begin
         instr_cnt_d = instr_cnt_q + 1'b1;
      end

      case (state_q)
         S_IDLE, S_HALTED: begin
            if (start) begin
               state_d = S_RUN;
            end else if (step) begin
               state_d = S_STEP;
            end
         end
         S_RUN: begin
            if (stop) begin
               stop_pend_d = 1'b1;
            end
            if (halt_hit) begin
               phase_d     = 3'd0;
               state_d     = S_HALTED;
               stop_pend_d = 1'b0;
            end else if (retire && (stop_pend_q || stop)) begin
               state_d     = S_IDLE;
               stop_pend_d = 1'b0;
            end
         end
         S_STEP: begin
            if (halt_hit) begin
               phase_d     = 3'd0;
               state_d     = S_HALTED;
               stop_pend_d = 1'b0;
            end else if (retire) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      running_d = (state_d == S_RUN) || (state_d == S_STEP);
      halted_d  = (state_d == S_HALTED);
   end

   // State registers. A synchronous reset abandons any instruction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RST_STATE;
         phase_q     <= 3'd0;
         div_cnt_q   <= '0;
         stop_pend_q <= 1'b0;
         instr_cnt_q <= '0;
         running_q   <= RUN_ON_RESET;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         div_cnt_q   <= div_cnt_d;
         stop_pend_q <= stop_pend_d;
         instr_cnt_q <= instr_cnt_d;
         running_q   <= running_d;
         halted_q    <= halted_d;
      end
   end

   assign phase     = phase_q;
   assign running   = running_q;
   assign halted    = halted_q;
   assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer. It uses three instances:
//   a: DIV=1, CNT_W=16, leaves reset idle  (run, halt, step, stop, reset)
//   b: DIV=3, CNT_W=16, leaves reset idle  (phase stretching, adv duty)
//   c: DIV=1, CNT_W=4,  leaves reset running (counter wrap)
// Inputs change 1 time unit after a rising edge. Outputs are checked at the
// same point, which is after the edge has settled.
module tb_phase_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // instance a
   logic a_rst = 1'b1, a_start = 1'b0, a_step = 1'b0, a_stop = 1'b0, a_halt = 1'b0;
   logic [2:0]  a_phase;
   logic        a_adv, a_running, a_halted;
   logic [15:0] a_cnt;

   // instance b
   logic b_rst = 1'b1, b_start = 1'b0, b_step = 1'b0, b_stop = 1'b0, b_halt = 1'b0;
   logic [2:0]  b_phase;
   logic        b_adv, b_running, b_halted;
   logic [15:0] b_cnt;

   // instance c
   logic c_rst = 1'b1, c_start = 1'b0, c_step = 1'b0, c_stop = 1'b0, c_halt = 1'b0;
   logic [2:0]  c_phase;
   logic        c_adv, c_running, c_halted;
   logic [3:0]  c_cnt;

   phase_sequencer #(.DIV(1), .CNT_W(16), .RUN_ON_RESET(1'b0)) dut_a (
      .clk(clk), .rst(a_rst), .start(a_start), .step(a_step), .stop(a_stop),
      .halt(a_halt), .phase(a_phase), .adv(a_adv), .running(a_running),
      .halted(a_halted), .instr_cnt(a_cnt));

   phase_sequencer #(.DIV(3), .CNT_W(16), .RUN_ON_RESET(1'b0)) dut_b (
      .clk(clk), .rst(b_rst), .start(b_start), .step(b_step), .stop(b_stop),
      .halt(b_halt), .phase(b_phase), .adv(b_adv), .running(b_running),
      .halted(b_halted), .instr_cnt(b_cnt));

   phase_sequencer #(.DIV(1), .CNT_W(4), .RUN_ON_RESET(1'b1)) dut_c (
      .clk(clk), .rst(c_rst), .start(c_start), .step(c_step), .stop(c_stop),
      .halt(c_halt), .phase(c_phase), .adv(c_adv), .running(c_running),
      .halted(c_halted), .instr_cnt(c_cnt));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      // ---------------- reset (all instances) ----------------
      a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
      tick;
      check("a_adv_in_rst", 32'(a_adv), 32'd0);
      tick;
      a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
      check("a_rst_phase",   32'(a_phase),   32'd0);
      check("a_rst_running", 32'(a_running), 32'd0);
      check("a_rst_halted",  32'(a_halted),  32'd0);
      check("a_rst_cnt",     32'(a_cnt),     32'd0);
      check("a_rst_adv",     32'(a_adv),     32'd0);
      check("c_rst_running", 32'(c_running), 32'd1);
      check("c_rst_phase",   32'(c_phase),   32'd0);

      // ---------------- test 1: DIV=1 run; halt outside phase 4 ignored ----
      tick;
      check("a_idle_phase", 32'(a_phase), 32'd0);
      a_start = 1'b1;
      tick;
      a_start = 1'b0;
      check("a_start_running", 32'(a_running), 32'd1);
      check("a_start_phase",   32'(a_phase),   32'd0);
      check("a_start_adv",     32'(a_adv),     32'd1);
      for (int k = 1; k <= 24; k++) begin
         a_halt = (((k - 1) % 8) != 4);
         tick;
         check("a_run_phase", 32'(a_phase), 32'(k % 8));
         if (k == 8)  check("a_cnt_8",  32'(a_cnt), 32'd1);
         if (k == 24) check("a_cnt_24", 32'(a_cnt), 32'd3);
      end
      check("a_run_halted", 32'(a_halted), 32'd0);

      // ---------------- test 3: halt held across an instruction ----------
      a_halt = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick;
         check("a_halt_phase", 32'(a_phase), 32'(k));
      end
      tick;
      a_halt = 1'b0;
      check("a_halt_phase0",  32'(a_phase),   32'd0);
      check("a_halt_halted",  32'(a_halted),  32'd1);
      check("a_halt_running", 32'(a_running), 32'd0);
      check("a_halt_cnt",     32'(a_cnt),     32'd3);
      check("a_halt_adv",     32'(a_adv),     32'd0);
      tick;
      check("a_halt_hold", 32'(a_phase), 32'd0);

      // ---------------- test 4: single step, then step+start -------------
      a_step = 1'b1;
      tick;
      a_step = 1'b0;
      check("a_step_running", 32'(a_running), 32'd1);
      check("a_step_halted",  32'(a_halted),  32'd0);
      for (int k = 1; k <= 7; k++) tick;
      check("a_step_p7", 32'(a_phase), 32'd7);
      tick;
      check("a_step_done_running", 32'(a_running), 32'd0);
      check("a_step_done_cnt",     32'(a_cnt),     32'd4);
      check("a_step_done_phase",   32'(a_phase),   32'd0);
      tick;
      check("a_step_idle_phase", 32'(a_phase),   32'd0);
      check("a_step_idle_run",   32'(a_running), 32'd0);
      a_step = 1'b1; a_start = 1'b1;
      tick;
      a_step = 1'b0; a_start = 1'b0;
      for (int k = 1; k <= 8; k++) tick;
      check("a_both_running", 32'(a_running), 32'd1);
      check("a_both_cnt",     32'(a_cnt),     32'd5);

      // ---------------- test 5: stop in phase 2, stop in phase 7 ---------
      tick; tick;
      check("a_stop_at_p2", 32'(a_phase), 32'd2);
      a_stop = 1'b1;
      tick;
      a_stop = 1'b0;
      for (int k = 4; k <= 7; k++) tick;
      check("a_stop_p7",      32'(a_phase),   32'd7);
      check("a_stop_p7_run",  32'(a_running), 32'd1);
      tick;
      check("a_stop_idle",    32'(a_running), 32'd0);
      check("a_stop_cnt",     32'(a_cnt),     32'd6);
      check("a_stop_phase",   32'(a_phase),   32'd0);
      a_start = 1'b1;
      tick;
      a_start = 1'b0;
      for (int k = 1; k <= 7; k++) tick;
      check("a_stop7_at_p7", 32'(a_phase), 32'd7);
      a_stop = 1'b1;
      tick;
      a_stop = 1'b0;
      check("a_stop7_idle",  32'(a_running), 32'd0);
      check("a_stop7_cnt",   32'(a_cnt),     32'd7);
      check("a_stop7_phase", 32'(a_phase),   32'd0);

      // ---------------- test 6: reset in phase 5 of RUN ------------------
      a_start = 1'b1;
      tick;
      a_start = 1'b0;
      for (int k = 1; k <= 5; k++) tick;
      check("a_mid_p5", 32'(a_phase), 32'd5);
      a_rst = 1'b1;
      #1;
      check("a_mid_adv_rst", 32'(a_adv), 32'd0);
      tick;
      a_rst = 1'b0;
      check("a_mid_phase",   32'(a_phase),   32'd0);
      check("a_mid_cnt",     32'(a_cnt),     32'd0);
      check("a_mid_running", 32'(a_running), 32'd0);
      check("a_mid_halted",  32'(a_halted),  32'd0);
      check("a_mid_adv",     32'(a_adv),     32'd0);

      // ---------------- test 2: DIV=3 phase stretching -------------------
      b_start = 1'b1;
      tick;
      b_start = 1'b0;
      check("b_start_running", 32'(b_running), 32'd1);
      for (int c = 0; c < 24; c++) begin
         check("b_phase", 32'(b_phase), 32'((c / 3) % 8));
         check("b_adv",   32'(b_adv),   32'((c % 3) == 2));
         tick;
      end
      check("b_wrap_phase", 32'(b_phase), 32'd0);
      check("b_cnt",        32'(b_cnt),   32'd1);

      // ---------------- test 6b: CNT_W=4 wraps after 16 ------------------
      // c has been running since its reset release; restart it cleanly.
      c_rst = 1'b1;
      tick;
      c_rst = 1'b0;
      for (int k = 1; k <= 136; k++) begin
         tick;
         if (k == 128) check("c_cnt_128", 32'(c_cnt), 32'd0);
      end
      check("c_cnt_136",   32'(c_cnt),   32'd1);
      check("c_phase_136", 32'(c_phase), 32'd0);
      check("c_running",   32'(c_running), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
